// File: rtl/cpu_host_loader.sv
//------------------------------------------------------------------------------
// Module   : cpu_host_loader
// Brief    : Host-side command executor that loads IMEM/DMEM, dumps DMEM and
//            pulses the CPU enable. Optional macro: CPU_HOST_LOADER_DUMP_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cpu_host_loader #(
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [63:0]      cmd_addr,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_data,
   output logic             busy,
   output logic             done,
   output logic             enable,
   output logic [63:0]      addr_ext,
   output logic             wen_ext,
   output logic             ren_ext,
   output logic [31:0]      wdata_ext,
   output logic [63:0]      addr_ext_2,
   output logic             wen_ext_2,
   output logic             ren_ext_2,
   output logic [63:0]      wdata_ext_2,
   input  logic [63:0]      rdata_ext_2
);

   localparam logic [1:0]       c_op_imem = 2'd0;
   localparam logic [1:0]       c_op_dmem = 2'd1;
   localparam logic [1:0]       c_op_dump = 2'd2;
   localparam logic [LEN_W-1:0] c_len_one = LEN_W'(1);
   localparam logic [LEN_W-1:0] c_len_zero = '0;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD     = 3'd1,
`ifdef CPU_HOST_LOADER_DUMP_EN
      S_DUMP_RD  = 3'd2,
      S_DUMP_CAP = 3'd3,
      S_DUMP_OUT = 3'd4,
`endif
      S_RUN      = 3'd5
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [1:0]       r_op, w_op_nxt;
   logic [63:0]      r_addr, w_addr_nxt;
   logic [LEN_W-1:0] r_rem, w_rem_nxt;

   logic             r_cmd_ready, r_in_ready, r_busy, r_done, r_enable;
   logic             r_wen_ext, r_wen_ext_2;
   logic [63:0]      r_addr_ext, r_addr_ext_2, r_wdata_ext_2;
   logic [31:0]      r_wdata_ext;

   logic             w_done_nxt, w_wen_nxt, w_wen2_nxt;
   logic [63:0]      w_addr_ext_nxt, w_addr_ext2_nxt, w_wdata2_nxt;
   logic [31:0]      w_wdata_nxt;

`ifdef CPU_HOST_LOADER_DUMP_EN
   logic             r_out_valid, r_ren_ext_2;
   logic [63:0]      r_out_data, w_out_data_nxt;
`endif

   always_ff @(posedge clk) begin
      if (srst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_op_nxt        = r_op;
      w_addr_nxt      = r_addr;
      w_rem_nxt       = r_rem;
      w_done_nxt      = 1'b0;
      w_wen_nxt       = 1'b0;
      w_wen2_nxt      = 1'b0;
      w_addr_ext_nxt  = r_addr_ext;
      w_wdata_nxt     = r_wdata_ext;
      w_addr_ext2_nxt = r_addr_ext_2;
      w_wdata2_nxt    = r_wdata_ext_2;
`ifdef CPU_HOST_LOADER_DUMP_EN
      w_out_data_nxt  = r_out_data;
`endif
      case (r_state)
         S_IDLE: begin
            if (cmd_valid && r_cmd_ready) begin
               w_op_nxt   = cmd_op;
               w_addr_nxt = cmd_addr;
               w_rem_nxt  = cmd_len;
               if (cmd_len == c_len_zero) begin
                  w_done_nxt = 1'b1;
               end else if (cmd_op == c_op_imem || cmd_op == c_op_dmem) begin
                  w_state_nxt = S_LOAD;
               end else if (cmd_op == c_op_dump) begin
`ifdef CPU_HOST_LOADER_DUMP_EN
                  w_state_nxt     = S_DUMP_RD;
                  w_addr_ext2_nxt = cmd_addr;
`else
                  w_done_nxt = 1'b1;
`endif
               end else begin
                  w_state_nxt = S_RUN;
               end
            end
         end
         S_LOAD: begin
            if (in_valid && r_in_ready) begin
               if (r_op == c_op_imem) begin
                  w_wen_nxt      = 1'b1;
                  w_addr_ext_nxt = r_addr;
                  w_wdata_nxt    = in_data[31:0];
                  w_addr_nxt     = r_addr + 64'd4;
               end else begin
                  w_wen2_nxt      = 1'b1;
                  w_addr_ext2_nxt = r_addr;
                  w_wdata2_nxt    = in_data;
                  w_addr_nxt      = r_addr + 64'd8;
               end
               w_rem_nxt = r_rem - c_len_one;
               if (r_rem == c_len_one) begin
                  w_state_nxt = S_IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
         end
`ifdef CPU_HOST_LOADER_DUMP_EN
         S_DUMP_RD:  w_state_nxt = S_DUMP_CAP;
         S_DUMP_CAP: begin
            w_out_data_nxt = rdata_ext_2;
            w_state_nxt    = S_DUMP_OUT;
         end
         S_DUMP_OUT: begin
            if (out_ready) begin
               w_addr_nxt = r_addr + 64'd8;
               w_rem_nxt  = r_rem - c_len_one;
               if (r_rem == c_len_one) begin
                  w_state_nxt = S_IDLE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt     = S_DUMP_RD;
                  w_addr_ext2_nxt = r_addr + 64'd8;
               end
            end
         end
`endif
         S_RUN: begin
            w_rem_nxt = r_rem - c_len_one;
            if (r_rem == c_len_one) begin
               w_state_nxt = S_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Status strobes are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (srst) begin
         r_op          <= 2'd0;
         r_addr        <= 64'd0;
         r_rem         <= c_len_zero;
         r_cmd_ready   <= 1'b1;
         r_in_ready    <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_enable      <= 1'b0;
         r_wen_ext     <= 1'b0;
         r_wen_ext_2   <= 1'b0;
         r_addr_ext    <= 64'd0;
         r_wdata_ext   <= 32'd0;
         r_addr_ext_2  <= 64'd0;
         r_wdata_ext_2 <= 64'd0;
      end else begin
         r_op          <= w_op_nxt;
         r_addr        <= w_addr_nxt;
         r_rem         <= w_rem_nxt;
         r_cmd_ready   <= (w_state_nxt == S_IDLE);
         r_in_ready    <= (w_state_nxt == S_LOAD);
         r_busy        <= (w_state_nxt != S_IDLE);
         r_done        <= w_done_nxt;
         r_enable      <= (w_state_nxt == S_RUN);
         r_wen_ext     <= w_wen_nxt;
         r_wen_ext_2   <= w_wen2_nxt;
         r_addr_ext    <= w_addr_ext_nxt;
         r_wdata_ext   <= w_wdata_nxt;
         r_addr_ext_2  <= w_addr_ext2_nxt;
         r_wdata_ext_2 <= w_wdata2_nxt;
      end
   end

`ifdef CPU_HOST_LOADER_DUMP_EN
   always_ff @(posedge clk) begin
      if (srst) begin
         r_out_valid <= 1'b0;
         r_ren_ext_2 <= 1'b0;
         r_out_data  <= 64'd0;
      end else begin
         r_out_valid <= (w_state_nxt == S_DUMP_OUT);
         r_ren_ext_2 <= (w_state_nxt == S_DUMP_RD);
         r_out_data  <= w_out_data_nxt;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign ren_ext_2 = r_ren_ext_2;
`else
   wire w_unused = ^{rdata_ext_2, out_ready};

   assign out_valid = 1'b0;
   assign out_data  = 64'd0;
   assign ren_ext_2 = 1'b0;
`endif

   assign cmd_ready   = r_cmd_ready;
   assign in_ready    = r_in_ready;
   assign busy        = r_busy;
   assign done        = r_done;
   assign enable      = r_enable;
   assign addr_ext    = r_addr_ext;
   assign wen_ext     = r_wen_ext;
   assign ren_ext     = 1'b0;
   assign wdata_ext   = r_wdata_ext;
   assign addr_ext_2  = r_addr_ext_2;
   assign wen_ext_2   = r_wen_ext_2;
   assign wdata_ext_2 = r_wdata_ext_2;

endmodule

`default_nettype wire

// File: tb/tb_cpu_host_loader.sv
//------------------------------------------------------------------------------
// Module   : tb_cpu_host_loader
// Brief    : Directed self-checking bench for cpu_host_loader with a small
//            DMEM model behind the data memory port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cpu_host_loader;

   localparam int LEN_W = 16;

   logic             clk = 1'b0;
   logic             srst;
   logic             cmd_valid, cmd_ready;
   logic [1:0]       cmd_op;
   logic [63:0]      cmd_addr;
   logic [LEN_W-1:0] cmd_len;
   logic             in_valid, in_ready;
   logic [63:0]      in_data;
   logic             out_valid, out_ready;
   logic [63:0]      out_data;
   logic             busy, done, enable;
   logic [63:0]      addr_ext;
   logic             wen_ext, ren_ext;
   logic [31:0]      wdata_ext;
   logic [63:0]      addr_ext_2;
   logic             wen_ext_2, ren_ext_2;
   logic [63:0]      wdata_ext_2;
   logic [63:0]      rdata_ext_2;

   int n_vec = 0;
   int n_err = 0;

   cpu_host_loader #(.LEN_W(LEN_W)) dut (
      .clk(clk), .srst(srst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .done(done), .enable(enable),
      .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
      .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
      .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
   );

   always #5 clk = ~clk;

   // Data memory model: 16 words, read data valid the cycle after ren_ext_2.
   logic [63:0] mem [16];
   always @(posedge clk) begin
      if (wen_ext_2) mem[addr_ext_2[6:3]] <= wdata_ext_2;
      if (ren_ext_2) rdata_ext_2 <= mem[addr_ext_2[6:3]];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [63:0] a, input logic [LEN_W-1:0] len);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = a;
      cmd_len   = len;
      tick();
      cmd_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 64'd0;
      rdata_ext_2 = 64'd0;
      srst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 64'd0; cmd_len = '0;
      in_valid = 1'b0; in_data = 64'd0; out_ready = 1'b0;
      tick(); tick();
      srst = 1'b0;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      chk("rst_strobes", {58'd0, done, enable, wen_ext, wen_ext_2, ren_ext_2, out_valid}, 64'd0);

      // Reset in the middle of a 5-word load
      send_cmd(2'd0, 64'h100, 16'd5);
      in_valid = 1'b1; in_data = 64'h1111;
      tick();
      chk("midload_wen", {63'd0, wen_ext}, 64'd1);
      srst = 1'b1;
      tick(); tick();
      srst = 1'b0; in_valid = 1'b0;
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      chk("midrst_wen", {63'd0, wen_ext}, 64'd0);
      chk("midrst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      chk("midrst_outs", {60'd0, in_ready, done, enable, ren_ext}, 64'd0);
      chk("midrst_addr", addr_ext, 64'd0);
      tick();
      chk("midrst_idle", {61'd0, busy, wen_ext, done}, 64'd0);

      // LOAD_IMEM back-to-back
      send_cmd(2'd0, 64'h0, 16'd3);
      chk("imem_in_ready", {62'd0, in_ready, busy}, 64'd3);
      in_valid = 1'b1; in_data = 64'hFFFF_0000_0050_0093;
      tick();
      chk("imem_w0", {wen_ext, done, addr_ext[29:0], wdata_ext}, {2'b10, 30'h0, 32'h0050_0093});
      in_data = 64'h0000_0000_00A0_0113;
      tick();
      chk("imem_w1", {wen_ext, done, addr_ext[29:0], wdata_ext}, {2'b10, 30'h4, 32'h00A0_0113});
      in_data = 64'h0000_0000_0020_81B3;
      tick();
      chk("imem_w2", {wen_ext, done, addr_ext[29:0], wdata_ext}, {2'b11, 30'h8, 32'h0020_81B3});
      chk("imem_w2_ready", {62'd0, in_ready, wen_ext_2}, 64'd0);
      in_valid = 1'b0;
      tick();
      chk("imem_after", {61'd0, wen_ext, done, busy}, 64'd0);

      // LOAD_DMEM with a two-cycle gap
      send_cmd(2'd1, 64'h10, 16'd2);
      in_valid = 1'b1; in_data = 64'hDEAD;
      tick();
      chk("dmem_w0", {62'd0, wen_ext_2, done}, 64'd2);
      chk("dmem_w0_addr", addr_ext_2, 64'h10);
      chk("dmem_w0_data", wdata_ext_2, 64'hDEAD);
      in_valid = 1'b0;
      tick();
      chk("dmem_gap1", {62'd0, wen_ext_2, wen_ext}, 64'd0);
      tick();
      chk("dmem_gap2", {62'd0, wen_ext_2, wen_ext}, 64'd0);
      in_valid = 1'b1; in_data = 64'hBEEF;
      tick();
      chk("dmem_w1", {62'd0, wen_ext_2, done}, 64'd3);
      chk("dmem_w1_addr", addr_ext_2, 64'h18);
      chk("dmem_w1_data", wdata_ext_2, 64'hBEEF);
      in_valid = 1'b0;
      tick();

      // DUMP_DMEM
      out_ready = 1'b0;
      send_cmd(2'd2, 64'h10, 16'd2);
`ifdef CPU_HOST_LOADER_DUMP_EN
      chk("dump_ren0", {63'd0, ren_ext_2}, 64'd1);
      chk("dump_ren0_addr", addr_ext_2, 64'h10);
      tick();
      chk("dump_cap0", {62'd0, ren_ext_2, out_valid}, 64'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("dump_hold_valid", {63'd0, out_valid}, 64'd1);
         chk("dump_hold_data", out_data, 64'hDEAD);
      end
      out_ready = 1'b1;
      tick();
      chk("dump_ren1", {61'd0, ren_ext_2, out_valid, done}, 64'd4);
      chk("dump_ren1_addr", addr_ext_2, 64'h18);
      tick();
      tick();
      chk("dump_out1", {62'd0, out_valid, done}, 64'd2);
      chk("dump_out1_data", out_data, 64'hBEEF);
      tick();
      chk("dump_done", {61'd0, out_valid, done, busy}, 64'd2);
      out_ready = 1'b0;
`else
      chk("dump_noop_done", {60'd0, done, busy, out_valid, ren_ext_2}, 64'd8);
      tick();
      chk("dump_noop_after", {61'd0, done, busy, out_valid}, 64'd0);
`endif
      tick();

      // RUN len 10
      send_cmd(2'd3, 64'h0, 16'd10);
      for (int i = 0; i < 10; i++) begin
         chk("run_enable", {59'd0, enable, done, wen_ext, wen_ext_2, ren_ext_2}, 64'h10);
         tick();
      end
      chk("run_done", {62'd0, enable, done}, 64'd1);
      tick();

      // RUN len 0
      send_cmd(2'd3, 64'h0, 16'd0);
      chk("run0_done", {61'd0, enable, done, busy}, 64'd2);
      tick();
      chk("run0_after", {62'd0, enable, done}, 64'd0);

      // IMEM address wrap
      send_cmd(2'd0, 64'hFFFF_FFFF_FFFF_FFFC, 16'd2);
      in_valid = 1'b1; in_data = 64'h1;
      tick();
      chk("wrap_addr0", addr_ext, 64'hFFFF_FFFF_FFFF_FFFC);
      in_data = 64'h2;
      tick();
      chk("wrap_addr1", addr_ext, 64'h0);
      chk("wrap_w1", {wen_ext, done, wdata_ext}, {2'b11, 32'h2});
      in_valid = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/cpu_host_loader.md
# cpu_host_loader

Host-side initiator for the CPU's external memory ports and run control. It accepts simple commands from a testbench or host link and executes them:
- bursts instruction words into instruction memory;
- bursts data words into data memory;
- reads data memory back out as a stream;
- raises `enable` for a fixed number of cycles.

It sits outside `cpu` and is the only driver of the `*_ext`, `*_ext_2` and `enable` inputs.

## Interface
Parameters:
- `LEN_W`, default 16: width of the command word/cycle count.

Ports:
- `clk`  in  1  main clock; all logic is on the rising edge.
- `srst`  in  1  synchronous, active-high reset.
- `cmd_valid` / `cmd_ready`  in/out  1/1  command handshake; transfer when both are high.
- `cmd_op`  in  2  0 = LOAD_IMEM, 1 = LOAD_DMEM, 2 = DUMP_DMEM, 3 = RUN.
- `cmd_addr`  in  64  start byte address; ignored for RUN.
- `cmd_len`  in  LEN_W  number of words, or number of enable cycles for RUN.
- `in_valid` / `in_ready` / `in_data`  in/out/in  1/1/64  load payload stream. IMEM uses only `in_data[31:0]`.
- `out_valid` / `out_ready` / `out_data`  out/in/out  1/1/64  dump stream.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a command completes.
- `enable`  out  1  to `cpu.enable`.
- `addr_ext`, `wen_ext`, `ren_ext`, `wdata_ext`  out  64/1/1/32  instruction memory external port. `ren_ext` is tied to 0.
- `addr_ext_2`, `wen_ext_2`, `ren_ext_2`, `wdata_ext_2`  out  64/1/1/64  data memory external port.
- `rdata_ext_2`  in  64  data memory read data. It is valid the cycle after `ren_ext_2` is high.

## Operation
- FSM states: IDLE, LOAD, DUMP_RD, DUMP_CAP, DUMP_OUT, RUN.
- IDLE:
  - `cmd_ready` = 1.
  - On handshake, latch op, addr and a remaining counter `rem` = `cmd_len`.
  - If `cmd_len` = 0: go to IDLE, pulse `done` next cycle, no memory traffic, no enable.
  - Otherwise go to LOAD (ops 0/1), DUMP_RD (op 2) or RUN (op 3).
- LOAD:
  - `in_ready` = 1.
  - Each `in` handshake registers a write that appears on the next cycle:
    - IMEM: `wen_ext` = 1, `addr_ext` = current addr, `wdata_ext` = `in_data[31:0]`.
    - DMEM: `wen_ext_2`, `addr_ext_2` and `wdata_ext_2` the same way, with full 64-bit data.
  - After each handshake: addr += 4 (IMEM) or 8 (DMEM), modulo 2^64, and `rem` -= 1.
  - When `rem` reaches 0, go to IDLE and pulse `done`; this coincides with the cycle of the final `wen` pulse.
  - Without an `in` handshake, `wen` is 0 that cycle.
- DUMP_RD: `ren_ext_2` = 1, `addr_ext_2` = addr, for exactly one cycle; then DUMP_CAP.
- DUMP_CAP: capture `rdata_ext_2` into the `out_data` register; then DUMP_OUT.
- DUMP_OUT:
  - `out_valid` = 1, with `out_data` stable until `out_ready`.
  - On handshake: addr += 8, `rem` -= 1.
  - If `rem` = 0, go to IDLE with a `done` pulse; otherwise go to DUMP_RD.
- RUN:
  - `enable` = 1 for exactly `cmd_len` consecutive cycles.
  - All `wen*`/`ren*` are 0 while `enable` = 1.
  - Then go to IDLE with a `done` pulse.
- Invariant: `enable` is never high together with any `wen_ext`, `wen_ext_2` or `ren_ext_2`.
- Invariant: `in_ready` and `out_valid` are 0 outside LOAD and DUMP_OUT respectively.

## Timing
- All outputs are registered.
- Reset values: state IDLE and every output 0, with one exception: `cmd_ready` = 1 from the first cycle after reset release.
- Reset mid-command: next cycle is IDLE with all strobes 0, and any pending write is dropped. Memory contents already written are left unchanged.
- Throughput:
  - Load: 1 word/cycle when `in_valid` is held high.
  - Dump: 1 word per 3 cycles at best.
- Latency:
  - Command accept to first RUN `enable`: 1 cycle.
  - Command accept to first DUMP `ren_ext_2`: 1 cycle.
- A new command is accepted only in IDLE. This can happen on the cycle `done` pulses, because `cmd_ready` is high in IDLE.

## Configuration
- `CPU_HOST_LOADER_DUMP_EN`
  - Defined: DUMP_DMEM is implemented as described.
  - Undefined:
    - The DUMP states are not compiled.
    - `out_valid`, `out_data` and `ren_ext_2` are tied to 0.
    - op 2 is accepted and completes as a no-op: `done` pulses the next cycle.

## Test plan
- Reset: hold `srst` 2 cycles during LOAD with `rem` = 5 → next cycle `busy` = 0, `wen_ext` = 0, `cmd_ready` = 1, all outputs 0.
- LOAD_IMEM, addr 0x0, len 3, `in_data` low words 0x00500093, 0x00A00113, 0x002081B3 back-to-back → `wen_ext` high 3 consecutive cycles at `addr_ext` 0x0/0x4/0x8 with those data, then `done` in the cycle of the third write.
- LOAD_DMEM, addr 0x10, len 2, `in_valid` gapped by 2 idle cycles → `wen_ext_2` at 0x10 then 0x18 only; no write in the gap cycles.
- DUMP_DMEM, addr 0x10, len 2, memory model returning 0xDEAD and 0xBEEF, `out_ready` held low 4 cycles → `out_data` stays 0xDEAD until accepted, then 0xBEEF, then `done`. Undefined-macro build: `done` the cycle after accept and `out_valid` never high.
- RUN, len 10 → `enable` high exactly 10 cycles, all `wen*`/`ren*` 0 throughout, `done` on the 11th. RUN len 0 → no `enable`, `done` next cycle.
- LOAD_IMEM at addr 0xFFFF_FFFF_FFFF_FFFC, len 2 → second write at `addr_ext` 0x0 (wrap).
